divider: RTL and testbench

Sequential restoring divider, the inverse operation of the shift-add multiplier in the same arithmetic group. It divides a 2W-bit unsigned dividend by a W-bit unsigned divisor and produces a W-bit quotient and a W-bit remainder, one quotient bit per clock. It serves the CPU core's DIV path and any emulation logic that needs wide division without a combinational divider. Operands are captured on a start pulse, and results are held stable until the next accepted start.

---
 rtl/divider_pkg.sv | 12 +
 rtl/divider_if.sv | 25 ++
 rtl/divider_step.sv | 27 ++
 rtl/divider.sv | 131 +++++++++++++
 tb/tb_divider.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
// Shared types and sizing constants for the sequential restoring divider.
package divider_pkg;

    localparam int DIV_W_DEFAULT     = 18;
    localparam int DIV_CNT_W_DEFAULT = $clog2(DIV_W_DEFAULT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } div_state_t;

endpackage

// File: rtl/divider_if.sv
// Request/result bundle of the divider: the requester drives the master side.
interface divider_if #(
    parameter int W = divider_pkg::DIV_W_DEFAULT
) ();

    logic             start;
    logic [2*W-1:0]   dividend;
    logic [W-1:0]     divisor;
    logic [W-1:0]     quotient;
    logic [W-1:0]     remainder;
    logic             busy;
    logic             done;
    logic             ovf;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, ovf
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, ovf
    );

endinterface

// File: rtl/divider_step.sv
// One restoring-division iteration: shift in a dividend bit, compare, subtract.
module divider_step #(
    parameter int W = divider_pkg::DIV_W_DEFAULT
) (
    input  logic [W:0]   i_rem,
    input  logic         i_bit,
    input  logic [W-1:0] i_divisor,
    output logic [W:0]   o_rem,
    output logic         o_qbit
);

    logic [W:0] w_shifted;
    logic [W:0] w_divisor_ext;

    assign w_shifted     = {i_rem[W-1:0], i_bit};
    assign w_divisor_ext = {1'b0, i_divisor};

    always_comb begin
        o_rem  = w_shifted;
        o_qbit = 1'b0;
        if (w_shifted >= w_divisor_ext) begin
            o_rem  = w_shifted - w_divisor_ext;
            o_qbit = 1'b1;
        end
    end

endmodule

// File: rtl/divider.sv
// Sequential restoring divider, 2W/W -> W quotient + W remainder, one bit per clock.
// Define DIVIDER_OVERFLOW_EN to detect quotient overflow at acceptance and finish in one cycle.
module divider
    import divider_pkg::*;
#(
    parameter int W = DIV_W_DEFAULT
) (
    input  logic      clk,
    input  logic      reset,
    divider_if.slave  bus
);

    localparam int CW = $clog2(W + 1);

    div_state_t      r_state, w_state_next;
    logic [W:0]      r_rem, w_rem_next;
    logic [W-1:0]    r_lo, w_lo_next;
    logic [W-1:0]    r_dvsr, w_dvsr_next;
    logic [W-1:0]    r_q, w_q_next;
    logic [CW-1:0]   r_cnt, w_cnt_next;
    logic [W-1:0]    r_quotient, w_quotient_next;
    logic [W-1:0]    r_remainder, w_remainder_next;
    logic            r_busy, w_busy_next;
    logic            r_done, w_done_next;
    logic            r_ovf, w_ovf_next;

    logic [W:0]      w_step_rem;
    logic            w_step_qbit;
    logic            w_ovf_cond;

    divider_step #(.W(W)) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_lo[W-1]),
        .i_divisor (r_dvsr),
        .o_rem     (w_step_rem),
        .o_qbit    (w_step_qbit)
    );

    // A high half >= divisor means the quotient cannot fit in W bits (covers divisor=0).
`ifdef DIVIDER_OVERFLOW_EN
    assign w_ovf_cond = (bus.dividend[2*W-1:W] >= bus.divisor);
`else
    assign w_ovf_cond = 1'b0;
`endif

    always_comb begin
        w_state_next     = r_state;
        w_rem_next       = r_rem;
        w_lo_next        = r_lo;
        w_dvsr_next      = r_dvsr;
        w_q_next         = r_q;
        w_cnt_next       = r_cnt;
        w_quotient_next  = r_quotient;
        w_remainder_next = r_remainder;
        w_busy_next      = r_busy;
        w_done_next      = 1'b0;
        w_ovf_next       = r_ovf;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (w_ovf_cond) begin
                        w_done_next = 1'b1;
                        w_ovf_next  = 1'b1;
                    end else begin
                        w_state_next = RUN;
                        w_rem_next   = {1'b0, bus.dividend[2*W-1:W]};
                        w_lo_next    = bus.dividend[W-1:0];
                        w_dvsr_next  = bus.divisor;
                        w_q_next     = '0;
                        w_cnt_next   = '0;
                        w_busy_next  = 1'b1;
                        w_ovf_next   = 1'b0;
                    end
                end
            end
            RUN: begin
                w_rem_next = w_step_rem;
                w_lo_next  = {r_lo[W-2:0], 1'b0};
                w_q_next   = {r_q[W-2:0], w_step_qbit};
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == CW'(W - 1)) begin
                    w_state_next     = IDLE;
                    w_busy_next      = 1'b0;
                    w_done_next      = 1'b1;
                    w_quotient_next  = {r_q[W-2:0], w_step_qbit};
                    w_remainder_next = w_step_rem[W-1:0];
                end
            end
            default: begin
                w_state_next = IDLE;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rem       <= '0;
            r_lo        <= '0;
            r_dvsr      <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_rem       <= w_rem_next;
            r_lo        <= w_lo_next;
            r_dvsr      <= w_dvsr_next;
            r_q         <= w_q_next;
            r_cnt       <= w_cnt_next;
            r_quotient  <= w_quotient_next;
            r_remainder <= w_remainder_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
            r_ovf       <= w_ovf_next;
        end
    end

    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: starts push expected results, a negedge monitor checks each done.
module tb_divider;
    import divider_pkg::*;

    localparam int W = 18;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    divider_if #(.W(W)) bus ();

    divider #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         ovf;
        int           due;
        int           busy_cyc;
        int           tag;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   busy_run  = 0;
    int   done_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, longint unsigned act, longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            busy_run = 0;
        end else begin
            if (bus.busy) busy_run++;
            if (bus.done) begin
                done_seen++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    $display("txn %0d: q=0x%0h r=0x%0h ovf=%0b cycle=%0d busy_cycles=%0d",
                             e.tag, bus.quotient, bus.remainder, bus.ovf, cyc, busy_run);
                    chk($sformatf("t%0d_quotient", e.tag), 64'(bus.quotient), 64'(e.q));
                    chk($sformatf("t%0d_remainder", e.tag), 64'(bus.remainder), 64'(e.r));
                    chk($sformatf("t%0d_ovf", e.tag), 64'(bus.ovf), 64'(e.ovf));
                    chk($sformatf("t%0d_done_cycle", e.tag), 64'(cyc), 64'(e.due));
                    chk($sformatf("t%0d_busy_cycles", e.tag), 64'(busy_run), 64'(e.busy_cyc));
                end
                busy_run = 0;
            end
        end
    end

    task automatic do_start(input logic [2*W-1:0] dd, input logic [W-1:0] dv, input bit push,
                            input logic [W-1:0] eq, input logic [W-1:0] er, input bit eo,
                            input int lat, input int bc, input int tag);
        exp_t e;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = dd;
        bus.divisor  = dv;
        if (push) begin
            e.q = eq; e.r = er; e.ovf = eo;
            e.due = cyc + 1 + lat;
            e.busy_cyc = bc;
            e.tag = tag;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = 36'({$urandom(), $urandom()});
        bus.divisor  = 18'($urandom());
    endtask

    task automatic wait_idle(input int tag);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL t%0d_timeout: got %0d pending results, expected 0", tag, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int seen;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_quotient", 64'(bus.quotient), 0);
        chk("reset_remainder", 64'(bus.remainder), 0);
        chk("reset_busy", 64'(bus.busy), 0);
        chk("reset_done", 64'(bus.done), 0);
        chk("reset_ovf", 64'(bus.ovf), 0);
        reset = 1'b0;

        // 100 / 7
        do_start(36'd100, 18'd7, 1'b1, 18'd14, 18'd2, 1'b0, W, W, 1);
        wait_idle(1);

`ifdef DIVIDER_OVERFLOW_EN
        // Overflow: previous quotient/remainder retained, one-cycle completion, no busy.
        do_start(36'h000040000, 18'd1, 1'b1, 18'd14, 18'd2, 1'b1, 0, 0, 2);
        wait_idle(2);
        do_start(36'd5, 18'd0, 1'b1, 18'd14, 18'd2, 1'b1, 0, 0, 3);
        wait_idle(3);
`endif

        // Largest quotient that fits
        do_start(36'hFFFFBFFFF, 18'h3FFFF, 1'b1, 18'h3FFFF, 18'h3FFFE, 1'b0, W, W, 4);
        wait_idle(4);

        // Start while busy is ignored
        do_start(36'd1000, 18'd10, 1'b1, 18'd100, 18'd0, 1'b0, W, W, 5);
        repeat (3) @(negedge clk);
        do_start(36'd9, 18'd3, 1'b0, 18'd0, 18'd0, 1'b0, 0, 0, 0);
        wait_idle(5);

        // Reset mid-operation discards the result
        do_start(36'd1000, 18'd10, 1'b0, 18'd0, 18'd0, 1'b0, 0, 0, 0);
        repeat (7) @(negedge clk);
        chk("t6_busy_before_reset", 64'(bus.busy), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_busy", 64'(bus.busy), 0);
        chk("t6_done", 64'(bus.done), 0);
        chk("t6_quotient", 64'(bus.quotient), 0);
        chk("t6_remainder", 64'(bus.remainder), 0);
        chk("t6_ovf", 64'(bus.ovf), 0);
        reset = 1'b0;
        seen = done_seen;
        repeat (30) @(negedge clk);
        chk("t6_no_done_after_reset", 64'(done_seen), 64'(seen));

        // Back-to-back: second start in the done cycle
        do_start(36'd100, 18'd7, 1'b1, 18'd14, 18'd2, 1'b0, W, W, 7);
        repeat (W - 1) @(negedge clk);
        do_start(36'd50, 18'd5, 1'b1, 18'd10, 18'd0, 1'b0, W, W, 8);
        wait_idle(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
